// File: rtl/mb_io_master_if.sv
// Command/response and MicroBlaze MCS IO bus signals seen by the IO bus initiator.
// The master modport is the initiator; the slave modport is the requester/IO-slave side.
interface mb_io_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [3:0]  cmd_be;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        IO_Addr_Strobe;
    logic        IO_Read_Strobe;
    logic        IO_Write_Strobe;
    logic [31:0] IO_Address;
    logic [3:0]  IO_Byte_Enable;
    logic [31:0] IO_Write_Data;
    logic [31:0] IO_Read_Data;
    logic        IO_Ready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
        input  IO_Read_Data, IO_Ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
        output IO_Address, IO_Byte_Enable, IO_Write_Data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_be, cmd_wdata,
        output IO_Read_Data, IO_Ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  IO_Addr_Strobe, IO_Read_Strobe, IO_Write_Strobe,
        input  IO_Address, IO_Byte_Enable, IO_Write_Data
    );
endinterface

// File: rtl/mb_io_master.sv
// MCS IO bus initiator: turns single-word commands into one strobed IO transaction
// and returns read data, or an error when the slave never answers.
module mb_io_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic           clk,
    input  logic           reset,
    mb_io_master_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STROBE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               LP_TMO_EN   = (TIMEOUT != 0);

    state_t           r_state;
    logic             r_write;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cmd_ready;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_rdata;
    logic             r_rsp_err;
    logic             r_addr_strobe;
    logic             r_read_strobe;
    logic             r_write_strobe;
    logic [31:0]      r_address;
    logic [3:0]       r_byte_enable;
    logic [31:0]      r_write_data;

    logic             w_timeout;
    logic [31:0]      w_ready_rdata;

    // The counter is checked before its increment, so the last WAIT cycle sees TIMEOUT-1.
    assign w_timeout     = LP_TMO_EN && (r_cnt == LP_CNT_LAST);
    assign w_ready_rdata = r_write ? 32'h0 : bus.IO_Read_Data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_write        <= 1'b0;
            r_cnt          <= '0;
            r_cmd_ready    <= 1'b1;
            r_rsp_valid    <= 1'b0;
            r_rsp_rdata    <= 32'h0;
            r_rsp_err      <= 1'b0;
            r_addr_strobe  <= 1'b0;
            r_read_strobe  <= 1'b0;
            r_write_strobe <= 1'b0;
            r_address      <= 32'h0;
            r_byte_enable  <= 4'h0;
            r_write_data   <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_write        <= bus.cmd_write;
                        r_address      <= bus.cmd_addr;
                        r_byte_enable  <= bus.cmd_be;
                        r_write_data   <= bus.cmd_wdata;
                        r_cmd_ready    <= 1'b0;
                        r_addr_strobe  <= 1'b1;
                        r_read_strobe  <= ~bus.cmd_write;
                        r_write_strobe <= bus.cmd_write;
                        r_state        <= ST_STROBE;
                    end
                end

                ST_STROBE: begin
                    r_addr_strobe  <= 1'b0;
                    r_read_strobe  <= 1'b0;
                    r_write_strobe <= 1'b0;
                    r_cnt          <= '0;
                    if (bus.IO_Ready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_ready_rdata;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else begin
                        r_state     <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A slave answer in the final cycle still wins over the timeout.
                    if (bus.IO_Ready) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_ready_rdata;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= 32'h0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= ST_RESP;
                    end
                end

                ST_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'h0;
                    r_rsp_err   <= 1'b0;
                    r_cnt       <= '0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready       = r_cmd_ready;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.rsp_err         = r_rsp_err;
    assign bus.IO_Addr_Strobe  = r_addr_strobe;
    assign bus.IO_Read_Strobe  = r_read_strobe;
    assign bus.IO_Write_Strobe = r_write_strobe;
    assign bus.IO_Address      = r_address;
    assign bus.IO_Byte_Enable  = r_byte_enable;
    assign bus.IO_Write_Data   = r_write_data;

endmodule

// File: tb/tb_mb_io_master.sv
// Directed bench for mb_io_master: write/read, timeout, ready-vs-timeout race,
// back-to-back commands with a spurious ready, and reset during WAIT.
module tb_mb_io_master;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n;

    mb_io_master_if bus ();

    mb_io_master #(.TIMEOUT(16), .CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_be    = be;
        bus.cmd_wdata = wdata;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.cmd_valid    = 1'b0;
        bus.cmd_write    = 1'b0;
        bus.cmd_addr     = 32'h0;
        bus.cmd_be       = 4'h0;
        bus.cmd_wdata    = 32'h0;
        bus.IO_Read_Data = 32'h0;
        bus.IO_Ready     = 1'b0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("rst_strobes", {29'd0, bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, 32'd0);
        chk("rst_addr", bus.IO_Address, 32'h0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Write, slave ready in the 2nd WAIT cycle
        issue(1'b1, 32'h0000_0008, 4'hF, 32'hDEAD_BEEF);
        tick();
        bus.cmd_valid = 1'b0;
        chk("wr_strobes", {29'd0, bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, 32'b101);
        chk("wr_addr", bus.IO_Address, 32'h8);
        chk("wr_data", bus.IO_Write_Data, 32'hDEAD_BEEF);
        chk("wr_be", 32'(bus.IO_Byte_Enable), 32'hF);
        chk("wr_cmdrdy", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("wr_w1_strb", {29'd0, bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, 32'd0);
        chk("wr_w1_addr", bus.IO_Address, 32'h8);
        tick();
        chk("wr_w2_rspv", 32'(bus.rsp_valid), 32'd0);
        bus.IO_Ready     = 1'b1;
        bus.IO_Read_Data = 32'hFFFF_0000;
        tick();
        bus.IO_Ready = 1'b0;
        chk("wr_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("wr_err", 32'(bus.rsp_err), 32'd0);
        chk("wr_rdata", bus.rsp_rdata, 32'h0);
        tick();
        chk("wr_idle_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("wr_idle_rdy", 32'(bus.cmd_ready), 32'd1);

        // Read, slave ready in the STROBE cycle
        issue(1'b0, 32'h0000_000C, 4'hF, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("rd_strobes", {29'd0, bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, 32'b110);
        chk("rd_addr", bus.IO_Address, 32'hC);
        bus.IO_Ready     = 1'b1;
        bus.IO_Read_Data = 32'h1234_5678;
        tick();
        bus.IO_Ready = 1'b0;
        chk("rd_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("rd_rdata", bus.rsp_rdata, 32'h1234_5678);
        chk("rd_err", 32'(bus.rsp_err), 32'd0);
        chk("rd_strb_off", 32'(bus.IO_Read_Strobe), 32'd0);
        tick();

        // Read with the slave never ready -> timeout
        bus.IO_Read_Data = 32'hFFFF_FFFF;
        issue(1'b0, 32'h0000_0010, 4'h3, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'd18);
        chk("tmo_err", 32'(bus.rsp_err), 32'd1);
        chk("tmo_rdata", bus.rsp_rdata, 32'h0);
        tick();
        chk("tmo_cmdrdy", 32'(bus.cmd_ready), 32'd1);
        chk("tmo_rspv_off", 32'(bus.rsp_valid), 32'd0);

        // IO_Ready in the very cycle the timeout would expire
        issue(1'b0, 32'h0000_0014, 4'hF, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        chk("race_pre_rspv", 32'(bus.rsp_valid), 32'd0);
        bus.IO_Ready     = 1'b1;
        bus.IO_Read_Data = 32'hA5A5_A5A5;
        tick();
        bus.IO_Ready = 1'b0;
        chk("race_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("race_err", 32'(bus.rsp_err), 32'd0);
        chk("race_rdata", bus.rsp_rdata, 32'hA5A5_A5A5);
        tick();

        // Back-to-back with cmd_valid held, IO_Ready high through RESP and IDLE
        issue(1'b0, 32'h0000_0020, 4'hF, 32'h0);
        tick();
        chk("b2b_strb1", 32'(bus.IO_Addr_Strobe), 32'd1);
        bus.IO_Ready     = 1'b1;
        bus.IO_Read_Data = 32'h1111_1111;
        tick();
        chk("b2b_rsp1", bus.rsp_rdata, 32'h1111_1111);
        chk("b2b_resp_strb", 32'(bus.IO_Addr_Strobe), 32'd0);
        bus.IO_Read_Data = 32'h3333_3333;
        bus.cmd_addr     = 32'h0000_0024;
        tick();
        chk("b2b_idle_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("b2b_idle_strb", 32'(bus.IO_Addr_Strobe), 32'd0);
        chk("b2b_idle_rdy", 32'(bus.cmd_ready), 32'd1);
        bus.IO_Read_Data = 32'h2222_2222;
        tick();
        bus.cmd_valid = 1'b0;
        chk("b2b_strb2", 32'(bus.IO_Addr_Strobe), 32'd1);
        chk("b2b_addr2", bus.IO_Address, 32'h24);
        tick();
        bus.IO_Ready = 1'b0;
        chk("b2b_rsp2", bus.rsp_rdata, 32'h2222_2222);
        tick();
        bus.IO_Ready = 1'b1;
        tick();
        bus.IO_Ready = 1'b0;
        chk("spur_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("spur_strb", 32'(bus.IO_Addr_Strobe), 32'd0);
        chk("spur_rdy", 32'(bus.cmd_ready), 32'd1);
        tick();
        chk("spur_rspv2", 32'(bus.rsp_valid), 32'd0);

        // Reset asserted during WAIT
        issue(1'b1, 32'h0000_0030, 4'h1, 32'h0000_00AA);
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("arst_strobes", {29'd0, bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, 32'd0);
        chk("arst_rspv", 32'(bus.rsp_valid), 32'd0);
        chk("arst_rdy", 32'(bus.cmd_ready), 32'd1);
        bus.IO_Ready = 1'b1;
        tick();
        bus.IO_Ready = 1'b0;
        reset = 1'b1;
        chk("arst_rspv2", 32'(bus.rsp_valid), 32'd0);
        tick();
        chk("post_rdy", 32'(bus.cmd_ready), 32'd1);
        issue(1'b0, 32'h0000_0040, 4'hF, 32'h0);
        tick();
        bus.cmd_valid = 1'b0;
        chk("post_strobes", {29'd0, bus.IO_Addr_Strobe, bus.IO_Read_Strobe, bus.IO_Write_Strobe}, 32'b110);
        tick();
        bus.IO_Ready     = 1'b1;
        bus.IO_Read_Data = 32'h0BAD_F00D;
        tick();
        bus.IO_Ready = 1'b0;
        chk("post_rspv", 32'(bus.rsp_valid), 32'd1);
        chk("post_rdata", bus.rsp_rdata, 32'h0BAD_F00D);
        chk("post_err", 32'(bus.rsp_err), 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mb_io_master.md
Name: mb_io_master

Overview:
- Bus initiator for the MicroBlaze MCS IO bus; it is the master end of the interface the existing IO slaves respond to.
- Converts single-word commands from a local requester (test sequencer, DMA front end, or bench driver) into IO bus transactions.
- Drives the address, read and write strobes, byte enables and write data, then waits for IO_Ready.
- Returns read data or a timeout error to the requester, so IO slaves can be exercised without the MCS core.

Parameters:
- TIMEOUT, 16, number of WAIT-state cycles without IO_Ready before the transaction is aborted with an error; 0 disables the timeout.
- CNT_W, 8, width of the timeout counter; TIMEOUT must be < 2^CNT_W.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  requester has a command.
- cmd_ready  output  1  master can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_addr  input  32  byte address.
- cmd_be  input  4  byte enables.
- cmd_wdata  input  32  write data.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  read data; 0 for writes and on error.
- rsp_err  output  1  transaction timed out; qualified by rsp_valid.
- IO_Addr_Strobe  output  1  address strobe, one cycle per transaction.
- IO_Read_Strobe  output  1  read strobe, coincident with IO_Addr_Strobe.
- IO_Write_Strobe  output  1  write strobe, coincident with IO_Addr_Strobe.
- IO_Address  output  32  transaction address.
- IO_Byte_Enable  output  4  byte enables.
- IO_Write_Data  output  32  write data.
- IO_Read_Data  input  32  slave read data, valid with IO_Ready.
- IO_Ready  input  1  slave completion, one-cycle pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except cmd_ready=1.
  - The timeout counter is cleared.
- All outputs are registered.
- State machine:
  - IDLE: cmd_ready=1. On cmd_valid=1 at a clock edge, latch cmd_write, cmd_addr, cmd_be and cmd_wdata, then go to STROBE.
  - STROBE (exactly 1 cycle):
    - cmd_ready=0 and IO_Addr_Strobe=1.
    - IO_Write_Strobe=cmd_write and IO_Read_Strobe=~cmd_write.
    - IO_Address, IO_Byte_Enable and IO_Write_Data are driven from the latched command.
    - If IO_Ready=1 at the edge, capture the response and go to RESP; otherwise go to WAIT.
  - WAIT:
    - All strobes are 0. Address, byte enables and write data hold their STROBE values.
    - The counter increments every cycle.
    - If IO_Ready=1, go to RESP with err=0.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1, go to RESP with err=1.
    - IO_Ready takes priority over the timeout when both occur in the same cycle.
  - RESP (exactly 1 cycle):
    - rsp_valid=1.
    - rsp_rdata = IO_Read_Data captured at the IO_Ready edge for a read, else 0.
    - rsp_err as determined above.
    - Next state is IDLE; the counter clears.
- There is no back-pressure on the response. The requester must accept rsp_valid in its cycle.
- Latency from the command-accept edge to rsp_valid:
  - 2 cycles if the slave is ready in the STROBE cycle.
  - 2+N cycles if the slave is ready in the Nth WAIT cycle (N>=1).
  - TIMEOUT+2 cycles on timeout.
- Throughput: a new command can be accepted no earlier than the cycle after RESP, i.e. at most one transaction every 3 cycles.
- IO_Address, IO_Byte_Enable and IO_Write_Data keep their last values in IDLE and RESP. Slaves qualify them only with strobes.
- IO_Ready while in IDLE or RESP (late or spurious) is ignored. No state change occurs and no rsp_valid is produced.
- cmd_valid in states other than IDLE is ignored; the command is not latched because cmd_ready=0.
- Reset asserted mid-transaction aborts it immediately. No rsp_valid is issued and strobes drop to 0 asynchronously.

Test Plan:
- Write 0xDEADBEEF to address 0x00000008 with be=4'hF; slave asserts IO_Ready in the 2nd WAIT cycle -> exactly one cycle with IO_Addr_Strobe=IO_Write_Strobe=1 and IO_Address=0x8; rsp_valid 4 cycles after accept with rsp_err=0 and rsp_rdata=0.
- Read address 0x0000000C; slave returns 0x12345678 with IO_Ready in the STROBE cycle -> IO_Read_Strobe=1 for one cycle; rsp_valid 2 cycles after accept with rsp_rdata=0x12345678.
- Read with the slave never ready and TIMEOUT=16 -> rsp_valid at accept+18 with rsp_err=1 and rsp_rdata=0; cmd_ready=1 on the next cycle.
- IO_Ready asserted in the same cycle the timeout would expire, with IO_Read_Data=0xA5A5A5A5 -> rsp_err=0 and rsp_rdata=0xA5A5A5A5.
- Back-to-back commands with cmd_valid held high, and a spurious IO_Ready pulse in IDLE -> second strobe exactly 3 cycles after the first when the slave responds in STROBE; no extra rsp_valid from the spurious pulse.
- reset driven low during WAIT -> all strobes and rsp_valid are 0 immediately; after release, cmd_ready=1 and a fresh read completes normally.
